// File: rtl/osiris_i_pkg.sv
// Shared fetch-path definitions: FSM states, bus widths and reset-time defaults.
package osiris_i_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam int unsigned        TIMEOUT_CYC_DEF = 255;
  localparam logic [XLEN-1:0]    NOP_INSTR_DEF   = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_hold_buf.sv
// One-entry instruction buffer between memory response and decode.
module instr_hold_buf
  import osiris_i_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic            ready,
  input  logic [XLEN-1:0] data_in,
  output logic [XLEN-1:0] data_out,
  output logic            valid
);

  // Clear beats load so a redirect never lets a stale word through.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid    <= 1'b0;
      data_out <= NOP_INSTR;
    end else if (load) begin
      valid    <= 1'b1;
      data_out <= data_in;
    end else if (valid && ready) begin
      valid    <= 1'b0;
      data_out <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction fetch responder: issues word reads to memory, buffers one
// instruction for decode, and handles redirects, misalignment and timeouts.
module imem_fetch_responder
  import osiris_i_pkg::*;
#(
  parameter int unsigned     TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR   = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            i_rst_IF,
  input  logic [XLEN-1:0] i_pc_IF,
  input  logic            i_req_IF,
  input  logic            i_flush_IF,
  input  logic            i_ready_ID,
  output logic [XLEN-1:0] o_instr_ID,
  output logic            o_valid_ID,
  output logic            o_stall_IF,
  output logic            o_err_IF,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata
);

  fetch_state_e     state;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept_c;
  logic             load_c;
  logic             timeout_c;

  assign o_stall_IF = (state != ST_IDLE) || (o_valid_ID && !i_ready_ID);
  assign accept_c   = i_req_IF && !o_stall_IF && !i_flush_IF;
  assign load_c     = (state == ST_WAIT) && i_mem_ack && !i_flush_IF;
  assign timeout_c  = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Request/ack state machine; ack always wins over timeout on the same cycle.
  always_ff @(posedge clk) begin
    if (i_rst_IF) begin
      state      <= ST_IDLE;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      o_err_IF   <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      o_err_IF <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept_c) begin
            if (i_pc_IF[1:0] != 2'b00) begin
              o_err_IF <= 1'b1;
            end else begin
              o_mem_addr <= i_pc_IF;
              o_mem_req  <= 1'b1;
              wait_cnt   <= '0;
              state      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            state     <= ST_IDLE;
          end else if (i_flush_IF) begin
            wait_cnt <= '0;
            state    <= ST_DROP;
          end else if (timeout_c) begin
            o_err_IF  <= 1'b1;
            o_mem_req <= 1'b0;
            wait_cnt  <= CNT_W'(TIMEOUT_CYC);
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DROP: begin
          // Killed request stays on the bus until memory answers, then the data is thrown away.
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            state     <= ST_IDLE;
          end else if (timeout_c) begin
            o_err_IF  <= 1'b1;
            o_mem_req <= 1'b0;
            wait_cnt  <= CNT_W'(TIMEOUT_CYC);
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          o_mem_req <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  instr_hold_buf #(
    .NOP_INSTR(NOP_INSTR)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (i_rst_IF),
    .load    (load_c),
    .clear   (i_flush_IF),
    .ready   (i_ready_ID),
    .data_in (i_mem_rdata),
    .data_out(o_instr_ID),
    .valid   (o_valid_ID)
  );

endmodule

// File: doc/imem_fetch_responder.md
IMEM_FETCH_RESPONDER -- requirements
Module: imem_fetch_responder

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum wait cycles for a memory acknowledge before the request is aborted.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction value driven while no valid instruction is held.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port i_rst_IF  input  1  reset, synchronous and active-high.
REQ-005 Port i_pc_IF  input  32  fetch address from the fetch stage.
REQ-006 Port i_req_IF  input  1  fetch request, qualified by !o_stall_IF.
REQ-007 Port i_flush_IF  input  1  redirect (taken branch/jump), which kills in-flight and buffered fetches.
REQ-008 Port i_ready_ID  input  1  decode can consume o_instr_ID this cycle.
REQ-009 Port o_instr_ID  output  32  fetched instruction.
REQ-010 Port o_valid_ID  output  1  o_instr_ID is valid.
REQ-011 Port o_stall_IF  output  1  fetch stage SHALL hold its PC while this is high.
REQ-012 Port o_err_IF  output  1  one-cycle pulse on a misaligned PC or a timeout.
REQ-013 Port o_mem_req  output  1  memory read request.
REQ-014 Port o_mem_addr  output  32  word-aligned memory read address.
REQ-015 Port i_mem_ack  input  1  memory read data valid.
REQ-016 Port i_mem_rdata  input  32  memory read data.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT and DROP.
REQ-018 A request SHALL be accepted when i_req_IF=1, o_stall_IF=0 and i_flush_IF=0.
- i_pc_IF is latched into o_mem_addr.
- o_mem_req goes high the next cycle.
- State moves IDLE->WAIT.
REQ-019 If an accepted PC has i_pc_IF[1:0]!=0, the block SHALL pulse o_err_IF for one cycle, issue no memory request, and remain in IDLE.
REQ-020 In WAIT, o_mem_req and o_mem_addr SHALL stay stable until i_mem_ack=1.
REQ-021 On i_mem_ack in WAIT (with no flush), the block SHALL load i_mem_rdata into a one-entry buffer, assert o_valid_ID the next cycle, and move to IDLE.
REQ-022 Memory latency SHALL be any value from 1 to TIMEOUT_CYC cycles; request to o_valid_ID SHALL be ack cycle +1.
REQ-023 The buffer SHALL hold o_instr_ID and o_valid_ID until a cycle with i_ready_ID=1, after which it clears or reloads.
REQ-024 o_stall_IF SHALL equal (state!=IDLE) OR (o_valid_ID AND !i_ready_ID).
REQ-025 Flush in WAIT without ack SHALL move the FSM to DROP, keeping o_mem_req high until ack.
- The ack in DROP is discarded and the FSM moves to IDLE.
REQ-026 Flush in the same cycle as an ack in WAIT SHALL discard that data and move the FSM to IDLE.
REQ-027 Flush in any state SHALL clear the buffer the next cycle (o_valid_ID=0, o_instr_ID=NOP_INSTR).
REQ-028 Flush together with i_req_IF SHALL not accept the request; fetch re-requests the target the next cycle.
REQ-029 An 8-bit wait counter SHALL:
- clear on entry to WAIT or DROP;
- increment each cycle without ack;
- saturate at TIMEOUT_CYC.
REQ-030 When the counter reaches TIMEOUT_CYC, the block SHALL:
- pulse o_err_IF;
- drop o_mem_req;
- discard any data;
- move to IDLE.
REQ-031 A late ack arriving in IDLE SHALL be ignored.
REQ-032 Back-to-back issue SHALL be possible: a new request is accepted in the IDLE cycle immediately after an ack, if the buffer will be free.

Reset
REQ-033 While i_rst_IF=1 at a clock edge, the block SHALL force:
- state to IDLE;
- o_mem_req=0, o_mem_addr=0;
- o_valid_ID=0, o_instr_ID=NOP_INSTR;
- o_err_IF=0, wait counter 0.
REQ-034 Reset during WAIT or DROP SHALL abandon the transaction, and any ack in the following cycles SHALL be ignored per REQ-031.
REQ-035 o_stall_IF SHALL be 0 in the first cycle after reset deasserts.

Structure
REQ-036 The FSM state enum, NOP_INSTR and the TIMEOUT_CYC default SHALL live in the shared package osiris_i_pkg.
REQ-037 The one-entry output buffer SHALL be a sub-module named instr_hold_buf, with ports load, clear, ready, data in and data out.

Verification
REQ-038 Reset, then PC=0x0000_0100 with ack 3 cycles later and data 0x0050_0093 -> o_mem_addr=0x100, o_valid_ID with 0x0050_0093 the cycle after ack, and o_stall_IF high for 4 cycles.
REQ-039 Flush 1 cycle after a request, ack 2 cycles later -> DROP state, data discarded, o_valid_ID stays 0, and IDLE after the ack.
REQ-040 Flush in the same cycle as an ack -> no o_valid_ID, buffer holds NOP_INSTR, and the next request is accepted the following cycle.
REQ-041 i_ready_ID=0 for 5 cycles after valid -> o_instr_ID stable, o_stall_IF=1 throughout, and no new o_mem_req.
REQ-042 No ack for 255 cycles -> single o_err_IF pulse, o_mem_req low, IDLE, and a late ack ignored.
REQ-043 PC=0x0000_0102 -> o_err_IF pulse, no o_mem_req, and o_valid_ID=0.
